aes_uart_link: RTL and testbench
================================

# aes_uart_link

UART front end for the AES core. It collects a 16-byte plaintext block from a serial 8N1 line, hands it to the AES core with a one-cycle start pulse, and waits for the core's ready flag. It then returns the 16-byte ciphertext over a serial 8N1 transmit line. It contains its own UART receiver and UART transmitter and sits between the board pins and the AES datapath.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per serial bit, for both RX and TX; must be ≥ 4.
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, idle high, 8N1, LSB first.
- tx  out  1  serial output, idle high, 8N1, LSB first.
- aes_ready  in  1  AES core result valid, level-sensitive.
- aes_start  out  1  one-cycle pulse that starts an AES operation.
- pt_to_aes  out  128  assembled plaintext.
- ct_from_aes  in  128  ciphertext from the AES core, sampled on capture.

## Operation
- Reset (async, active-high) sets:
  - tx=1, aes_start=0, pt_to_aes=0
  - byte counter=0
  - state=RX_COLLECT
  - RX and TX sub-FSMs to IDLE
- rx passes through a 2-flop synchronizer before use.
- UART receiver:
  - IDLE: waits for a sync'd low on the line.
  - START: checks the line at CLKS_PER_BIT/2. If it is high, this is a false start; return to IDLE with no byte.
  - DATA: samples 8 bits at mid-bit, each CLKS_PER_BIT apart, LSB first.
  - STOP: samples the stop bit at mid-bit. 1 means the byte is valid and a one-cycle rx_valid pulse is issued. 0 means a framing error; the byte is discarded and no pulse is issued.
  - Returns to IDLE after STOP.
- UART transmitter: on tx_start with tx_din, it drives:
  - start bit 0 for CLKS_PER_BIT cycles
  - 8 data bits LSB first, CLKS_PER_BIT cycles each
  - stop bit 1 for CLKS_PER_BIT cycles
  - then a one-cycle tx_done pulse
  - tx_start is ignored while busy.
- Top FSM:
  - RX_COLLECT: each rx_valid byte is shifted into pt_to_aes: pt_to_aes <= {pt_to_aes[119:0], byte}. The first byte ends in bits [127:120]. When the 16th byte arrives, go to START_AES.
  - START_AES: aes_start=1 for exactly one cycle; pt_to_aes is held stable; go to WAIT_AES.
  - WAIT_AES: on the first cycle aes_ready=1, latch ct_from_aes into a 128-bit shift register and go to TX_SEND.
  - TX_SEND: transmit 16 bytes, most significant byte (ct[127:120]) first. After the 16th tx_done, clear the byte counter and return to RX_COLLECT.
- aes_ready is ignored in every state except WAIT_AES.
- rx_valid bytes arriving outside RX_COLLECT are discarded.
- pt_to_aes keeps its value until the first byte of the next block shifts in.

## Timing
- Received byte: rx_valid is asserted 2 sync cycles + 9.5×CLKS_PER_BIT cycles after the falling edge of the start bit (±1 cycle).
- aes_start is asserted the cycle after the 16th rx_valid.
- The ct latch happens on the rising edge where aes_ready is seen high in WAIT_AES.
- The first tx start bit begins the cycle after the latch.
- Each TX frame is 10×CLKS_PER_BIT cycles.
- The next frame's start bit begins the cycle after the previous tx_done. Block TX therefore takes 16×(10×CLKS_PER_BIT+1) cycles.
- Reset mid-frame or mid-block aborts immediately: tx returns high, and partial plaintext and counters are cleared.
- Counters are wide enough for CLKS_PER_BIT and wrap only by explicit clear, never by overflow.

## Test plan
- **Plaintext assembly:** with CLKS_PER_BIT=87, send bytes 00,11,22,…,FF, one frame per 1000 cycles.
  - pt_to_aes = 128'h00112233445566778899AABBCCDDEEFF.
  - aes_start is high for exactly 1 cycle, after the 16th byte.
- **Ciphertext return:** after that, set ct_from_aes=128'hdeadbeefdeadbeefdeadbeefdeadbeef and aes_ready=1 (held high).
  - tx emits DE AD BE EF ×4, each as a 870-cycle 8N1 frame, LSB first.
  - No second aes_start and no retransmission follow.
- **Early aes_ready:** hold aes_ready=1 during RX_COLLECT after 5 bytes.
  - No capture and no TX occur.
  - Capture occurs only after the block completes.
- **False start:** a 20-cycle low glitch on rx produces no byte; the counter is unchanged.
- **Framing error:** a frame with stop bit 0 is discarded; the following valid 16 bytes are assembled correctly.
- **Reset mid-block:** pulse reset after 7 bytes, or during TX byte 3.
  - Outputs take their reset values immediately.
  - A fresh 16-byte block then works normally.

Source files
------------

// File: rtl/aes_uart_link.sv
// -----------------------------------------------------------------------------
// aes_uart_link
//
// UART front end for an AES core. Sixteen bytes arriving on an 8N1 serial
// line are assembled into a 128-bit plaintext block (first byte in the top
// bits). The block is handed to the core with a one-cycle start pulse. When
// the core raises its ready flag, the ciphertext is captured and sent back
// over an 8N1 serial line, most significant byte first.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit for RX and TX (must be >= 4)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   rx           serial input, idle high, 8N1, LSB first
//   tx           serial output, idle high, 8N1, LSB first
//   aes_ready    AES result valid (level); only looked at while waiting
//   aes_start    one-cycle pulse starting an AES operation
//   pt_to_aes    assembled 128-bit plaintext
//   ct_from_aes  128-bit ciphertext, sampled when aes_ready is seen
// -----------------------------------------------------------------------------
module aes_uart_link #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    output logic         tx,
    input  logic         aes_ready,
    output logic         aes_start,
    output logic [127:0] pt_to_aes,
    input  logic [127:0] ct_from_aes
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_COLLECT, START_AES, WAIT_AES, TX_SEND} link_state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. Both flops come out of reset high (line idle) so a
    // reset never looks like a start bit.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples values from before the clock edge, independent of the order
    // of statements and blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // -------------------------------------------------------------------------
    // UART receiver
    // -------------------------------------------------------------------------
    rx_state_t        rx_state, rx_state_d;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic [7:0]       rx_shift, rx_shift_d;
    logic             rx_valid, rx_valid_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_valid_d = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line half a bit in; high means a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                // A low stop bit is a framing error: drop the byte silently.
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_valid_d = rx_sync;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_valid <= rx_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // UART transmitter. tx_done is a registered pulse in the first idle cycle
    // after the stop bit; a tx_start in that same cycle begins the next frame
    // on the following edge, giving a 10*CLKS_PER_BIT+1 cycle frame period.
    // -------------------------------------------------------------------------
    tx_state_t        tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_shift, tx_shift_d;
    logic             tx_done, tx_done_d;
    logic             tx_q, tx_line_d;
    logic             tx_start;
    logic [7:0]       tx_din;

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_done_d  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_shift_d = tx_din;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit + 3'd1;
                        tx_shift_d = {1'b1, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level follows the next state so the pin is a clean flop output.
        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_done  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_done  <= tx_done_d;
            tx_q     <= tx_line_d;
        end
    end

    // -------------------------------------------------------------------------
    // Link FSM: collect 16 bytes, start AES, wait for the result, send it back.
    // byte_cnt counts received bytes while collecting and frames started while
    // sending.
    // -------------------------------------------------------------------------
    link_state_t  state, state_d;
    logic [4:0]   byte_cnt, byte_cnt_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_sr, ct_sr_d;
    logic         aes_start_q, aes_start_d;

    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        pt_d       = pt_q;
        ct_sr_d    = ct_sr;
        tx_start   = 1'b0;
        tx_din     = ct_sr[127:120];
        case (state)
            RX_COLLECT: begin
                if (rx_valid) begin
                    pt_d = {pt_q[119:0], rx_shift};
                    if (byte_cnt == 5'd15) begin
                        byte_cnt_d = '0;
                        state_d    = START_AES;
                    end else begin
                        byte_cnt_d = byte_cnt + 5'd1;
                    end
                end
            end
            START_AES: begin
                state_d = WAIT_AES;
            end
            WAIT_AES: begin
                // The first byte goes straight from the core's bus so its
                // start bit begins on the edge right after the capture.
                if (aes_ready) begin
                    tx_start   = 1'b1;
                    tx_din     = ct_from_aes[127:120];
                    ct_sr_d    = {ct_from_aes[119:0], 8'h00};
                    byte_cnt_d = 5'd1;
                    state_d    = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_done) begin
                    if (byte_cnt == 5'd16) begin
                        byte_cnt_d = '0;
                        state_d    = RX_COLLECT;
                    end else begin
                        tx_start   = 1'b1;
                        ct_sr_d    = {ct_sr[119:0], 8'h00};
                        byte_cnt_d = byte_cnt + 5'd1;
                    end
                end
            end
            default: state_d = RX_COLLECT;
        endcase
        aes_start_d = (state_d == START_AES);
    end

    // NOTE: the plaintext and ciphertext registers are plain flops, not a RAM,
    // so they take the reset; a reset must wipe any partial plaintext.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RX_COLLECT;
            byte_cnt    <= '0;
            pt_q        <= '0;
            ct_sr       <= '0;
            aes_start_q <= 1'b0;
        end else begin
            state       <= state_d;
            byte_cnt    <= byte_cnt_d;
            pt_q        <= pt_d;
            ct_sr       <= ct_sr_d;
            aes_start_q <= aes_start_d;
        end
    end

    assign tx        = tx_q;
    assign aes_start = aes_start_q;
    assign pt_to_aes = pt_q;

endmodule

// File: tb/tb_aes_uart_link.sv
// -----------------------------------------------------------------------------
// tb_aes_uart_link
//
// Randomized bench for aes_uart_link. A byte-level model predicts each
// plaintext block and the ciphertext byte stream; monitors compare aes_start /
// pt_to_aes and the decoded tx frames against those predictions.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_uart_link;

    localparam int CPB = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic         tx;
    logic         aes_ready = 1'b0;
    logic         aes_start;
    logic [127:0] pt_to_aes;
    logic [127:0] ct_from_aes = '0;

    aes_uart_link #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .tx         (tx),
        .aes_ready  (aes_ready),
        .aes_start  (aes_start),
        .pt_to_aes  (pt_to_aes),
        .ct_from_aes(ct_from_aes)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]   blk_q[$];      // bytes of the block being collected
    logic [127:0] exp_pt_q[$];   // expected plaintext per aes_start
    logic [7:0]   exp_tx_q[$];   // expected ciphertext bytes on tx
    bit           collecting = 1'b1;
    int           epoch = 0;     // bumped on every reset to void in-flight frames
    int           tx_low_cnt = 0;

    always @(negedge clk) if (tx === 1'b0) tx_low_cnt++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ct(input logic [127:0] ct);
        for (int i = 0; i < 16; i++) exp_tx_q.push_back(ct[127 - 8*i -: 8]);
    endtask

    task automatic model_rx_byte(input logic [7:0] b);
        logic [127:0] pt;
        if (!collecting) return;
        blk_q.push_back(b);
        if (blk_q.size() == 16) begin
            pt = '0;
            for (int i = 0; i < 16; i++) pt[127 - 8*i -: 8] = blk_q[i];
            exp_pt_q.push_back(pt);
            blk_q.delete();
            collecting = 1'b0;
            if (aes_ready) push_ct(ct_from_aes);
        end
    endtask

    // Drive one 8N1 frame. A bad frame has a low stop bit held past mid-bit.
    task automatic send_frame(input logic [7:0] b, input bit good_stop);
        if (good_stop) model_rx_byte(b);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good_stop;
        repeat (good_stop ? CPB : CPB/2 + 4) @(negedge clk);
        rx = 1'b1;
        repeat (good_stop ? $urandom_range(1, CPB) : 2*CPB) @(negedge clk);
    endtask

    task automatic send_glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB/4) @(negedge clk);
        rx = 1'b1;
        repeat (2*CPB) @(negedge clk);
    endtask

    task automatic send_random_block(input int nbytes);
        for (int i = 0; i < nbytes; i++) send_frame(8'($urandom()), 1'b1);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic release_ct(input logic [127:0] ct);
        @(negedge clk);
        ct_from_aes = ct;
        push_ct(ct);
        aes_ready = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_tx_q.size() != 0 || exp_pt_q.size() != 0) && n < 20*11*CPB) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(exp_tx_q.size() + exp_pt_q.size()), 128'(0));
        repeat (2*CPB) @(negedge clk);
        collecting = 1'b1;
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check({name, "_tx"}, 128'(tx), 128'(1));
        check({name, "_aes_start"}, 128'(aes_start), 128'(0));
        check({name, "_pt"}, pt_to_aes, 128'(0));
        epoch++;
        blk_q.delete();
        exp_pt_q.delete();
        exp_tx_q.delete();
        collecting = 1'b1;
        aes_ready  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // aes_start monitor: one-cycle pulse, plaintext as predicted
    initial begin : pt_monitor
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev) check("aes_start_width", 128'(aes_start), 128'(0));
            if (aes_start === 1'b1 && !prev) begin
                check("aes_start_expected", 128'(exp_pt_q.size() != 0), 128'(1));
                if (exp_pt_q.size() != 0) check("pt_to_aes", pt_to_aes, exp_pt_q.pop_front());
            end
            prev = (aes_start === 1'b1);
        end
    end

    // tx monitor: decode 8N1 frames at mid-bit and compare with the model
    initial begin : tx_monitor
        logic [7:0] data;
        logic       st;
        logic       sp;
        int         ep;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ep = epoch;
                repeat (CPB/2 - 1) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    data[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                sp = tx;
                if (ep == epoch) begin
                    check("tx_start_bit", 128'(st), 128'(0));
                    check("tx_stop_bit", 128'(sp), 128'(1));
                    check("tx_byte_expected", 128'(exp_tx_q.size() != 0), 128'(1));
                    if (exp_tx_q.size() != 0) check("tx_byte", 128'(data), 128'(exp_tx_q.pop_front()));
                end
            end
        end
    end

    initial begin : stimulus
        int           base;
        int           n;
        logic [127:0] ct;

        repeat (2) @(negedge clk);
        check("por_tx", 128'(tx), 128'(1));
        check("por_aes_start", 128'(aes_start), 128'(0));
        check("por_pt", pt_to_aes, 128'(0));
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Block A: 00,11,...,FF; one extra byte while waiting is dropped
        for (int i = 0; i < 16; i++) send_frame(8'(i * 17), 1'b1);
        send_frame(8'hA5, 1'b1);
        check("block_a_pt", pt_to_aes, 128'h00112233445566778899AABBCCDDEEFF);
        release_ct(128'hdeadbeefdeadbeefdeadbeefdeadbeef);
        wait_drain("block_a_drain");
        base = tx_low_cnt;
        repeat (30*CPB) @(negedge clk);
        check("no_retransmit", 128'(tx_low_cnt - base), 128'(0));
        aes_ready = 1'b0;

        // Block B: aes_ready raised early, after 5 bytes
        ct = rand128();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                ct_from_aes = ct;
                aes_ready   = 1'b1;
                base        = tx_low_cnt;
            end
            if (i == 15) check("no_tx_before_block_done", 128'(tx_low_cnt - base), 128'(0));
            send_frame(8'($urandom()), 1'b1);
        end
        wait_drain("block_b_drain");
        aes_ready = 1'b0;

        // Block C: framing error, then a glitch in the middle of a good block
        send_frame(8'h3C, 1'b0);
        send_random_block(3);
        send_glitch();
        send_random_block(13);
        release_ct(rand128());
        wait_drain("block_c_drain");
        aes_ready = 1'b0;

        // Block D: reset after 7 bytes
        send_random_block(7);
        pulse_reset("rst_mid_block");

        // Block E: reset while tx is inside byte 3 (all-zero byte)
        send_random_block(16);
        ct = rand128();
        ct[111:104] = 8'h00;
        release_ct(ct);
        n = 0;
        while (exp_tx_q.size() > 14 && n < 4*11*CPB) begin
            @(negedge clk);
            n++;
        end
        check("tx_reached_byte3", 128'(exp_tx_q.size()), 128'(14));
        repeat (3*CPB) @(negedge clk);
        check("tx_low_in_byte3", 128'(tx), 128'(0));
        pulse_reset("rst_mid_tx");

        // Block F: fresh block after reset
        send_random_block(16);
        release_ct(rand128());
        wait_drain("block_f_drain");
        aes_ready = 1'b0;
        repeat (4*CPB) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
